// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: merges in-order load responses with ALU results,
// tracks outstanding load destinations in a tag FIFO and a busy scoreboard, and
// raises a sticky error on protocol violations.
module reg_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,
    input  logic            issue_load_i,
    input  logic [4:0]      issue_rd_i,
    output logic            ld_ready_o,
    input  logic            ld_valid_i,
    input  logic [XLEN-1:0] ld_data_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    output logic            stall_o,
    output logic [4:0]      a3_o,
    output logic [XLEN-1:0] wd3_o,
    output logic            en_o,
    output logic            err_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

    logic [4:0]      tag_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic [31:0]     busy_q, busy_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    logic            en_q, en_d;
    logic            err_q, err_d;

    logic       empty, full, pop, push, ld_err, issue_bad;
    logic       alu_go, alu_waw, alu_wr;
    logic [4:0] head;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DepthCnt);
    assign head      = tag_q[rd_ptr_q];
    assign pop       = ld_valid_i && !empty;
    assign ld_err    = ld_valid_i && empty;
    // A same-cycle pop frees a slot, so a full queue only blocks issue without a response.
    assign issue_bad = (full && !ld_valid_i) || ((issue_rd_i != 5'd0) && busy_q[issue_rd_i]);
    assign push      = issue_load_i && !issue_bad;
    // Load responses own the write port; the ALU source holds its result while blocked.
    assign alu_go    = alu_valid_i && !ld_valid_i;
    assign alu_waw   = alu_go && (alu_rd_i != 5'd0) && busy_q[alu_rd_i];
    assign alu_wr    = alu_go && !alu_waw;

    assign alu_ready_o = !ld_valid_i;
    assign ld_ready_o  = !full;
    assign stall_o     = ((rs1_i != 5'd0) && busy_q[rs1_i]) || ((rs2_i != 5'd0) && busy_q[rs2_i]);
    assign a3_o        = a3_q;
    assign wd3_o       = wd3_q;
    assign en_o        = en_q;
    assign err_o       = err_q;

    // Next-state for queue occupancy, scoreboard, write port and error flag.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear lands with the register-file write; a same-edge set of that register wins.
        busy_d = busy_q;
        if (en_q) begin
            busy_d[a3_q] = 1'b0;
        end
        if (push && (issue_rd_i != 5'd0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;

        a3_d  = a3_q;
        wd3_d = wd3_q;
        en_d  = 1'b0;
        if (pop) begin
            a3_d  = head;
            wd3_d = ld_data_i;
            en_d  = (head != 5'd0);
        end else if (alu_wr) begin
            a3_d  = alu_rd_i;
            wd3_d = alu_data_i;
            en_d  = (alu_rd_i != 5'd0);
        end

        err_d = err_q | (issue_load_i && issue_bad) | ld_err | alu_waw;
    end

    // Control state; reset discards any loads in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            a3_q     <= '0;
            wd3_q    <= '0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            busy_q  <= busy_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_q[wr_ptr_q] <= issue_rd_i;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: a queue/scoreboard model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_reg_writeback;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            alu_ready;
    logic            issue_load = 1'b0;
    logic [4:0]      issue_rd = '0;
    logic            ld_ready;
    logic            ld_valid = 1'b0;
    logic [XLEN-1:0] ld_data = '0;
    logic [4:0]      rs1 = '0;
    logic [4:0]      rs2 = '0;
    logic            stall;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic            en;
    logic            err;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    reg_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .alu_valid_i  (alu_valid),
        .alu_rd_i     (alu_rd),
        .alu_data_i   (alu_data),
        .alu_ready_o  (alu_ready),
        .issue_load_i (issue_load),
        .issue_rd_i   (issue_rd),
        .ld_ready_o   (ld_ready),
        .ld_valid_i   (ld_valid),
        .ld_data_i    (ld_data),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .stall_o      (stall),
        .a3_o         (a3),
        .wd3_o        (wd3),
        .en_o         (en),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered tag list, busy set, and the last write-port values.
    int              mq[$];
    bit [31:0]       mbusy;
    bit              men;
    bit [4:0]        ma3;
    bit [XLEN-1:0]   mwd3;
    bit              merr;

    always @(posedge clk or negedge rst_n) begin
        bit        ok_issue, alu_go, waw, old_en;
        bit [4:0]  old_a3;
        int        head;
        if (!rst_n) begin
            mq.delete();
            mbusy = '0;
            men   = 1'b0;
            ma3   = '0;
            mwd3  = '0;
            merr  = 1'b0;
        end else begin
            old_en = men;
            old_a3 = ma3;
            ok_issue = issue_load && (mq.size() < DEPTH || ld_valid)
                       && !(issue_rd != 0 && mbusy[issue_rd]);
            if (issue_load && !ok_issue) merr = 1'b1;
            alu_go = alu_valid && !ld_valid;
            waw    = alu_go && alu_rd != 0 && mbusy[alu_rd];
            if (waw) merr = 1'b1;
            men = 1'b0;
            if (ld_valid && mq.size() == 0) begin
                merr = 1'b1;
            end else if (ld_valid) begin
                head = mq.pop_front();
                ma3  = 5'(head);
                mwd3 = ld_data;
                men  = (head != 0);
            end else if (alu_go && !waw) begin
                ma3  = alu_rd;
                mwd3 = alu_data;
                men  = (alu_rd != 0);
            end
            if (old_en) mbusy[old_a3] = 1'b0;
            if (ok_issue) begin
                mq.push_back(int'(issue_rd));
                if (issue_rd != 0) mbusy[issue_rd] = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("m_en", en, men);
            chk("m_a3", a3, ma3);
            chk("m_wd3", wd3, mwd3);
            chk("m_err", err, merr);
            chk("m_ld_ready", ld_ready, mq.size() < DEPTH);
            chk("m_alu_ready", alu_ready, !ld_valid);
            chk("m_stall", stall, (rs1 != 0 && mbusy[rs1]) || (rs2 != 0 && mbusy[rs2]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alu_valid  = 1'b0;
        issue_load = 1'b0;
        ld_valid   = 1'b0;
    endtask

    initial begin
        int tags[5];
        tags = '{1, 2, 3, 4, 8};

        // Reset state
        step();
        started = 1'b1;
        step();
        #1;
        chk("rst_en", en, 0);
        chk("rst_a3", a3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_err", err, 0);
        chk("rst_ld_ready", ld_ready, 1);
        rst_n = 1'b1;

        // Single ALU write, one-cycle pulse
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        step();
        idle();
        #1;
        chk("alu_en", en, 1);
        chk("alu_a3", a3, 5);
        chk("alu_wd3", wd3, 32'h1234);
        step();
        #1;
        chk("alu_en_drop", en, 0);
        chk("alu_a3_hold", a3, 5);

        // Load to x7 with dependent source
        issue_load = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        rs1 = 5'd7;
        #1;
        chk("ld7_stall", stall, 1);
        step();
        ld_valid = 1'b1; ld_data = 32'hCAFE;
        #1;
        chk("ld7_alu_ready", alu_ready, 0);
        step();
        idle();
        #1;
        chk("ld7_en", en, 1);
        chk("ld7_a3", a3, 7);
        chk("ld7_wd3", wd3, 32'hCAFE);
        chk("ld7_stall_hold", stall, 1);
        step();
        #1;
        chk("ld7_stall_drop", stall, 0);
        rs1 = 5'd0;

        // Fill the tag queue, overflow, then drain in order with a concurrent issue
        for (int i = 1; i <= 4; i++) begin
            issue_load = 1'b1; issue_rd = 5'(i);
            step();
        end
        issue_rd = 5'd5;
        #1;
        chk("full_ld_ready", ld_ready, 0);
        chk("full_err_pre", err, 0);
        step();
        idle();
        #1;
        chk("ovf_err", err, 1);
        chk("ovf_ld_ready", ld_ready, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            idle();
            ld_valid = 1'b1; ld_data = 32'h101 + i;
            if (i == 0) begin
                issue_load = 1'b1; issue_rd = 5'd8;
            end
            #1;
            if (i > 0) begin
                chk("drain_en", en, 1);
                chk("drain_a3", a3, tags[i-1]);
                chk("drain_wd3", wd3, 32'h101 + i - 1);
            end
            if (i == 1) chk("pop_push_ld_ready", ld_ready, 0);
        end
        step();
        idle();
        #1;
        chk("drain_last_a3", a3, 8);
        chk("drain_last_wd3", wd3, 32'h105);
        chk("drain_ld_ready", ld_ready, 1);

        // Load and ALU collide: load first, held ALU result next
        issue_load = 1'b1; issue_rd = 5'd9;
        step();
        idle();
        ld_valid = 1'b1; ld_data = 32'hAAAA;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hBBBB;
        #1;
        chk("col_alu_ready", alu_ready, 0);
        step();
        ld_valid = 1'b0;
        #1;
        chk("col_ld_a3", a3, 9);
        chk("col_ld_wd3", wd3, 32'hAAAA);
        chk("col_alu_ready_back", alu_ready, 1);
        step();
        idle();
        #1;
        chk("col_alu_en", en, 1);
        chk("col_alu_a3", a3, 10);
        chk("col_alu_wd3", wd3, 32'hBBBB);

        // Writes to x0 never enable and never stall
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        issue_load = 1'b1; issue_rd = 5'd0;
        step();
        idle();
        #1;
        chk("x0_alu_en", en, 0);
        chk("x0_alu_a3", a3, 0);
        chk("x0_stall", stall, 0);
        step();
        ld_valid = 1'b1; ld_data = 32'h77;
        step();
        idle();
        #1;
        chk("x0_ld_en", en, 0);
        chk("x0_ld_wd3", wd3, 32'h77);

        // WAW: ALU to a register with a load outstanding
        issue_load = 1'b1; issue_rd = 5'd12;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h1;
        step();
        idle();
        #1;
        chk("waw_en", en, 0);
        ld_valid = 1'b1; ld_data = 32'h12;
        step();
        idle();
        #1;
        chk("waw_ld_a3", a3, 12);
        chk("waw_ld_wd3", wd3, 32'h12);

        // Reset with loads pending
        issue_load = 1'b1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd6;
        step();
        idle();
        rs1 = 5'd3; rs2 = 5'd6;
        #1;
        chk("pend_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ld_ready", ld_ready, 1);
        chk("arst_stall", stall, 0);
        chk("arst_err", err, 0);
        chk("arst_en", en, 0);
        step();
        rst_n = 1'b1;
        rs1 = 5'd0; rs2 = 5'd0;
        step();
        ld_valid = 1'b1; ld_data = 32'h99;
        step();
        idle();
        #1;
        chk("post_rst_err", err, 1);
        chk("post_rst_en", en, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of load-tag queue entries (power of 2, at least 2).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning width of the data path.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 ALU_VALID  in  1  ALU result present this cycle.
REQ-006 ALU_RD  in  5  ALU destination register.
REQ-007 ALU_DATA  in  XLEN  ALU result.
REQ-008 ALU_READY  out  1  ALU result accepted this cycle; combinational, equal to !LD_VALID.
REQ-009 ISSUE_LOAD  in  1  load issued this cycle; destination is ISSUE_RD.
REQ-010 ISSUE_RD  in  5  load destination register.
REQ-011 LD_READY  out  1  tag queue not full.
REQ-012 LD_VALID  in  1  load data returning; responses SHALL arrive in issue order.
REQ-013 LD_DATA  in  XLEN  returned load data.
REQ-014 RS1, RS2  in  5 each  source registers of the instruction in decode.
REQ-015 STALL  out  1  combinational; 1 when RS1 or RS2 is nonzero and its busy bit is set.
REQ-016 A3  out  5  register-file write address, registered.
REQ-017 WD3  out  XLEN  register-file write data, registered.
REQ-018 EN  out  1  register-file write enable, registered.
REQ-019 ERR  out  1  sticky protocol-error flag.

Function
REQ-020 The block SHALL hold a DEPTH-entry FIFO of load destinations and a 32-bit busy vector; busy[0] SHALL always read 0.
REQ-021 An accepted issue SHALL push ISSUE_RD into the FIFO; if ISSUE_RD != 0, it SHALL set busy[ISSUE_RD] at the same edge.
REQ-022 An issue SHALL be rejected (no push, no busy change, ERR set) when the FIFO is full and LD_VALID=0, or when busy[ISSUE_RD]=1 and ISSUE_RD != 0.
REQ-023 An issue with LD_VALID=1 in the same cycle SHALL be accepted even when the FIFO is full (pop and push together).
REQ-024 LD_VALID=1 with a non-empty FIFO SHALL pop the head tag and register A3=head, WD3=LD_DATA, EN=(head!=0) at the same edge.
REQ-025 LD_VALID=1 with an empty FIFO SHALL be ignored except that ERR is set.
REQ-026 When LD_VALID=0 and ALU_VALID=1, the block SHALL register A3=ALU_RD, WD3=ALU_DATA, EN=(ALU_RD!=0).
REQ-027 ALU_VALID=1 with ALU_RD nonzero and busy (WAW) SHALL NOT produce a write, and ERR SHALL be set.
REQ-028 Load responses SHALL have priority over ALU results; an ALU result offered while ALU_READY=0 SHALL be held stable by the source.
REQ-029 When no write is selected, EN SHALL be 0 next cycle; A3 and WD3 SHALL hold their previous values.
REQ-030 Write latency SHALL be 1 cycle: accept edge -> EN/A3/WD3 valid for exactly one cycle.
REQ-031 busy[A3] SHALL clear on the edge where EN=1 (the same edge the register file writes), so STALL drops only once the value is architecturally visible.
REQ-032 When a set (REQ-021) and a clear (REQ-031) target the same register on the same edge, the set SHALL win.
REQ-033 LD_READY SHALL equal (count < DEPTH); FIFO pointers SHALL wrap modulo DEPTH.
REQ-034 ERR SHALL remain 1 until reset.

Reset
REQ-035 RST_N=0 SHALL immediately force EN=0, A3=0, WD3=0, ERR=0, FIFO empty (LD_READY=1), and all busy bits to 0, discarding loads in flight.
REQ-036 After RST_N deasserts, the block SHALL accept traffic on the first rising edge.

Verification
REQ-037 ALU_VALID, ALU_RD=5, ALU_DATA=0x1234 -> next cycle EN=1, A3=5, WD3=0x1234; following cycle EN=0.
REQ-038 Issue load rd=7; RS1=7 -> STALL=1; LD_VALID with LD_DATA=0xCAFE -> EN=1, A3=7, WD3=0xCAFE next cycle; STALL=0 one cycle after that.
REQ-039 Issue 4 loads (rd 1..4) -> LD_READY=0; fifth issue with LD_VALID=0 -> ERR=1, FIFO unchanged; responses write 1,2,3,4 in order.
REQ-040 LD_VALID and ALU_VALID in the same cycle -> ALU_READY=0, load written first, ALU result written the cycle after.
REQ-041 ALU_RD=0 and load to x0 -> EN stays 0, tag popped, STALL never asserted for x0.
REQ-042 RST_N pulsed low with 2 loads pending -> LD_READY=1, STALL=0, ERR=0 at once; later LD_VALID -> ERR=1, no write.
